axis_packetizer: RTL and testbench

- Downstream stage of axis_data_width_converter. Consumes its master stream, which carries tdata/tvalid/tready only.
- Produces a full AXIS master stream for the capture sink: tlast framing every PACKET_BEATS accepted beats, tkeep all ones, constant tuser/tdest.
- Includes a two-entry skid buffer, so every output is registered and s_axis_tready has no combinational path from m_axis_tready.

---
 rtl/axis_packetizer.sv | 117 +++++++++++
 tb/tb_axis_packetizer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: adds tlast/tkeep/tuser/tdest framing to a bare data stream
// behind a two-entry skid buffer so every output, including s_axis_tready, is registered.
module axis_packetizer #(
  parameter int BUS_WIDTH    = 4,
  parameter int USER_WIDTH   = 1,
  parameter int DEST_WIDTH   = 1,
  parameter int PACKET_BEATS = 16,
  parameter int DEST_VALUE   = 0
) (
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [BUS_WIDTH*8-1:0]  s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [BUS_WIDTH*8-1:0]  m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [BUS_WIDTH-1:0]    m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  output logic [DEST_WIDTH-1:0]   m_axis_tdest,
  output logic [15:0]             beat_count
);

  localparam logic [15:0] LAST_IDX = 16'(PACKET_BEATS - 1);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                  state;
  logic                    s_rdy;
  logic [BUS_WIDTH*8-1:0]  data_p0;
  logic                    last_p0;
  logic [BUS_WIDTH*8-1:0]  data_p1;
  logic                    last_p1;
  logic                    vld_p1;
  logic [BUS_WIDTH-1:0]    keep_p1;
  logic [15:0]             cnt;

  logic in_acc;
  logic out_acc;
  logic in_last;

  function automatic logic [15:0] next_count(input logic [15:0] c);
    return (c == LAST_IDX) ? 16'd0 : c + 16'd1;
  endfunction

  assign in_acc  = s_axis_tvalid & s_rdy;
  assign out_acc = vld_p1 & m_axis_tready;
  assign in_last = (cnt == LAST_IDX);

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state   <= EMPTY;
      s_rdy   <= 1'b0;
      data_p0 <= '0;
      last_p0 <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      vld_p1  <= 1'b0;
      keep_p1 <= '0;
      cnt     <= 16'd0;
    end else begin
      s_rdy <= 1'b1;
      if (in_acc)
        cnt <= next_count(cnt);
      case (state)
        EMPTY: begin
          if (in_acc) begin
            data_p1 <= s_axis_tdata;
            last_p1 <= in_last;
            vld_p1  <= 1'b1;
            keep_p1 <= '1;
            state   <= ONE;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            data_p1 <= s_axis_tdata;
            last_p1 <= in_last;
          end else if (in_acc) begin
            // Output is stalled: park the new beat and close the input on this same edge.
            data_p0 <= s_axis_tdata;
            last_p0 <= in_last;
            s_rdy   <= 1'b0;
            state   <= FULL;
          end else if (out_acc) begin
            vld_p1 <= 1'b0;
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (out_acc) begin
            data_p1 <= data_p0;
            last_p1 <= last_p0;
            state   <= ONE;
          end else begin
            s_rdy <= 1'b0;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= EMPTY;
        end
      endcase
    end
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tvalid = vld_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tlast  = last_p1;
  assign m_axis_tuser  = '0;
  assign m_axis_tdest  = DEST_WIDTH'(DEST_VALUE);
  assign beat_count    = cnt;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: three instances (PACKET_BEATS 4, 16, 1) share one
// input stream; a queue model predicts data, ready/valid, framing and beat_count.
module tb_axis_packetizer;
  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        m_ready = 1'b0;

  logic        s_rdy   [3];
  logic [31:0] m_data  [3];
  logic        m_valid [3];
  logic [3:0]  m_keep  [3];
  logic        m_last  [3];
  logic        m_user  [3];
  logic        m_dest  [3];
  logic [15:0] bcnt    [3];

  int          n_tests = 0;
  int          n_fail  = 0;
  int          tot_in  = 0;
  int          tot_out = 0;
  int          lasts   [3];
  logic [31:0] data_next = 32'd1;
  logic [31:0] q [$];

  always #5 aclk = ~aclk;

  axis_packetizer #(.PACKET_BEATS(4), .DEST_VALUE(0)) u_pb4 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy[0]),
    .m_axis_tdata(m_data[0]), .m_axis_tvalid(m_valid[0]), .m_axis_tready(m_ready),
    .m_axis_tkeep(m_keep[0]), .m_axis_tlast(m_last[0]), .m_axis_tuser(m_user[0]),
    .m_axis_tdest(m_dest[0]), .beat_count(bcnt[0]));

  axis_packetizer #(.PACKET_BEATS(16), .DEST_VALUE(1)) u_pb16 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy[1]),
    .m_axis_tdata(m_data[1]), .m_axis_tvalid(m_valid[1]), .m_axis_tready(m_ready),
    .m_axis_tkeep(m_keep[1]), .m_axis_tlast(m_last[1]), .m_axis_tuser(m_user[1]),
    .m_axis_tdest(m_dest[1]), .beat_count(bcnt[1]));

  axis_packetizer #(.PACKET_BEATS(1), .DEST_VALUE(0)) u_pb1 (
    .aclk(aclk), .arstn(arstn),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_rdy[2]),
    .m_axis_tdata(m_data[2]), .m_axis_tvalid(m_valid[2]), .m_axis_tready(m_ready),
    .m_axis_tkeep(m_keep[2]), .m_axis_tlast(m_last[2]), .m_axis_tuser(m_user[2]),
    .m_axis_tdest(m_dest[2]), .beat_count(bcnt[2]));

  function automatic int pb(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // One-cycle reset pulse, then release; checks reset values and the first ready cycle.
  task automatic do_reset();
    arstn   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check("rst_m_valid", m_valid[i], 1'b0);
      check("rst_m_data", m_data[i], 32'd0);
      check("rst_m_last", m_last[i], 1'b0);
      check("rst_m_keep", m_keep[i], 4'h0);
      check("rst_s_ready", s_rdy[i], 1'b0);
      check("rst_beat_count", bcnt[i], 16'd0);
    end
    arstn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      check("post_rst_s_ready", s_rdy[i], 1'b1);
      lasts[i] = 0;
    end
    q.delete();
    tot_in  = 0;
    tot_out = 0;
  endtask

  // mode 0: continuous valid/ready; 1: random valid/ready; 2: ready low 5 cycles from stall_at
  task automatic xfer(input int n, input int mode, input int stall_at);
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          first_out = -1;
    int          last_out = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;
    logic        in_acc;
    logic        out_acc;
    logic [31:0] exp_d;
    while (got < n && cyc < 20000) begin
      s_valid = (sent < n) && (mode != 1 || $urandom_range(0, 1) == 1);
      s_data  = data_next;
      case (mode)
        1:       m_ready = ($urandom_range(0, 3) != 0);
        2:       m_ready = !(cyc >= stall_at && cyc < stall_at + 5);
        default: m_ready = 1'b1;
      endcase
      for (int i = 0; i < 3; i++) begin
        check("s_ready", s_rdy[i], (q.size() < 2));
        check("m_valid", m_valid[i], (q.size() > 0));
        check("beat_count", bcnt[i], 16'(tot_in % pb(i)));
      end
      if (prev_stall)
        check("stall_stable_data", m_data[0], prev_data);
      in_acc  = s_valid && (q.size() < 2);
      out_acc = m_ready && (q.size() > 0);
      prev_stall = !m_ready && (q.size() > 0);
      prev_data  = m_data[0];
      if (out_acc) begin
        exp_d = q.pop_front();
        for (int i = 0; i < 3; i++) begin
          check("m_data", m_data[i], exp_d);
          check("m_last", m_last[i], ((tot_out % pb(i)) == pb(i) - 1));
          check("m_keep", m_keep[i], 4'hF);
          check("m_user", m_user[i], 1'b0);
          check("m_dest", m_dest[i], (i == 1));
          lasts[i] += int'(m_last[i]);
        end
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        got++;
        tot_out++;
      end
      if (in_acc) begin
        q.push_back(s_data);
        sent++;
        tot_in++;
        data_next++;
      end
      step();
      cyc++;
    end
    s_valid = 1'b0;
    check("xfer_complete", got, n);
    if (mode == 0)
      check("throughput_cycles", last_out - first_out + 1, n);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) lasts[i] = 0;

    do_reset();
    xfer(8, 0, 0);
    check("pb4_lasts_8beats", lasts[0], 2);
    xfer(8, 2, 2);
    check("pb4_lasts_stall", lasts[0], 4);

    do_reset();
    xfer(5, 0, 0);
    check("pb1_lasts_5beats", lasts[2], 5);
    check("pb1_beat_count", bcnt[2], 16'd0);

    do_reset();
    xfer(1000, 1, 0);
    check("pb16_packets", lasts[1], 62);
    check("pb16_remainder", bcnt[1], 16'd8);
    check("pb4_packets", lasts[0], 250);
    check("pb1_packets", lasts[2], 1000);

    // Three beats of a 4-beat packet out, fourth held, then a reset pulse discards it.
    do_reset();
    xfer(3, 0, 0);
    check("mid_beat_count", bcnt[0], 16'd3);
    s_valid = 1'b1;
    s_data  = data_next;
    m_ready = 1'b0;
    step();
    s_valid = 1'b0;
    check("mid_held_valid", m_valid[0], 1'b1);
    check("mid_held_last", m_last[0], 1'b1);
    check("mid_held_data", m_data[0], data_next);
    data_next++;
    do_reset();
    xfer(4, 0, 0);
    check("post_rst_packet_lasts", lasts[0], 1);
    check("post_rst_beat_count", bcnt[0], 16'd0);

    xfer(32, 0, 0);
    check("b2b_lasts", lasts[0], 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
